// File: rtl/reorder_commit_unit.sv
// In-order commit engine: retires up to RETIRE_WIDTH micro-ops per cycle against
// per-queue completion credits and moves the pending ID to the committed FIFO on a breakpoint.
module reorder_commit_unit #(
    parameter int   NUM_QUEUES   = 8,
    parameter int   DEPTH        = 64,
    parameter int   ID_DEPTH     = 16,
    parameter int   COMMIT_DEPTH = 16,
    parameter int   ID_WIDTH     = 6,
    parameter int   RETIRE_WIDTH = 2,
    parameter logic BREAKPOINT   = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    output logic                              full_o,
    input  logic                              trace_push_i,
    input  logic [$clog2(NUM_QUEUES)-1:0]     trace_sel_i,
    input  logic                              trace_break_i,
    input  logic                              trace_id_push_i,
    input  logic [ID_WIDTH-1:0]               trace_id_value_i,
    input  logic [NUM_QUEUES-1:0]             queues_status_push_i,
    input  logic                              commit_id_pull_i,
    output logic                              commit_id_valid_o,
    output logic [ID_WIDTH-1:0]               commit_id_value_o,
    output logic                              commit_id_full_o,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count_o,
    output logic                              credit_err_o
);
    localparam int SW  = $clog2(NUM_QUEUES);
    localparam int AW  = $clog2(DEPTH);
    localparam int IW  = $clog2(ID_DEPTH);
    localparam int CAW = $clog2(COMMIT_DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RCW = $clog2(RETIRE_WIDTH + 1);

    // trace entry: {sel, brk}
    logic [SW:0]         r_tmem [DEPTH];
    logic [AW:0]         r_twr, r_trd;
    logic [ID_WIDTH-1:0] r_imem [ID_DEPTH];
    logic [IW:0]         r_iwr, r_ird;
    logic [ID_WIDTH-1:0] r_cmem [COMMIT_DEPTH];
    logic [CAW:0]        r_cwr, r_crd;
    logic [CW-1:0]       r_cred [NUM_QUEUES];
    logic                r_err;

    logic [AW:0]         w_tcnt;
    logic [IW:0]         w_icnt;
    logic [CAW:0]        w_ccnt;
    logic                w_tfull, w_ifull, w_iempty, w_cfull, w_cvalid;
    logic                w_tpush, w_ipush, w_cpull;
    logic [RCW-1:0]      w_used [NUM_QUEUES];
    logic [RCW-1:0]      w_ret_cnt;
    logic                w_commit, w_go, w_brk;
    logic [AW-1:0]       w_idx;
    logic [SW-1:0]       w_sel;

    assign w_tcnt   = r_twr - r_trd;
    assign w_icnt   = r_iwr - r_ird;
    assign w_ccnt   = r_cwr - r_crd;
    assign w_tfull  = (w_tcnt == (AW+1)'(DEPTH));
    assign w_ifull  = (w_icnt == (IW+1)'(ID_DEPTH));
    assign w_iempty = (w_icnt == '0);
    assign w_cfull  = (w_ccnt == (CAW+1)'(COMMIT_DEPTH));
    assign w_cvalid = (w_ccnt != '0);
    assign w_tpush  = trace_push_i && !w_tfull && !flush_i && !rst_i;
    assign w_ipush  = trace_id_push_i && !w_ifull && !flush_i && !rst_i;
    assign w_cpull  = commit_id_pull_i && w_cvalid;

    // w_used doubles as the running same-queue count of earlier slots, since
    // every earlier slot must already have retired for the scan to reach slot k.
    always_comb begin
        w_ret_cnt = '0;
        w_commit  = 1'b0;
        w_go      = !flush_i && !rst_i;
        w_idx     = '0;
        w_sel     = '0;
        w_brk     = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) w_used[q] = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            w_idx = r_trd[AW-1:0] + AW'(k);
            w_sel = r_tmem[w_idx][SW:1];
            w_brk = r_tmem[w_idx][0];
            if (w_go && ((AW+1)'(k) < w_tcnt) && (r_cred[w_sel] > CW'(w_used[w_sel])) &&
                (!w_brk || (!w_iempty && !w_cfull))) begin
                w_used[w_sel] = w_used[w_sel] + RCW'(1);
                w_ret_cnt     = w_ret_cnt + RCW'(1);
                if (w_brk) begin
                    w_commit = 1'b1;
                    w_go     = 1'b0;
                end
            end else begin
                w_go = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tpush) r_tmem[r_twr[AW-1:0]] <= {trace_sel_i, trace_break_i == BREAKPOINT};
        if (w_ipush) r_imem[r_iwr[IW-1:0]] <= trace_id_value_i;
        if (w_commit && !rst_i) r_cmem[r_cwr[CAW-1:0]] <= r_imem[r_ird[IW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_twr <= '0;
            r_trd <= '0;
            r_iwr <= '0;
            r_ird <= '0;
            r_cwr <= '0;
            r_crd <= '0;
            r_err <= 1'b0;
            for (int q = 0; q < NUM_QUEUES; q++) r_cred[q] <= '0;
        end else begin
            if (w_commit) r_cwr <= r_cwr + (CAW+1)'(1);
            if (w_cpull)  r_crd <= r_crd + (CAW+1)'(1);
            if (flush_i) begin
                r_twr <= '0;
                r_trd <= '0;
                r_iwr <= '0;
                r_ird <= '0;
                for (int q = 0; q < NUM_QUEUES; q++) r_cred[q] <= '0;
            end else begin
                if (w_tpush)  r_twr <= r_twr + (AW+1)'(1);
                r_trd <= r_trd + (AW+1)'(w_ret_cnt);
                if (w_ipush)  r_iwr <= r_iwr + (IW+1)'(1);
                if (w_commit) r_ird <= r_ird + (IW+1)'(1);
                for (int q = 0; q < NUM_QUEUES; q++) begin
                    if (queues_status_push_i[q] && (r_cred[q] == CW'(DEPTH)) && (w_used[q] == '0))
                        r_err <= 1'b1;
                    else
                        r_cred[q] <= r_cred[q] + CW'(queues_status_push_i[q]) - CW'(w_used[q]);
                end
            end
        end
    end

    assign full_o            = w_tfull || w_ifull;
    assign commit_id_valid_o = w_cvalid;
    assign commit_id_value_o = w_cvalid ? r_cmem[r_crd[CAW-1:0]] : '0;
    assign commit_id_full_o  = w_cfull;
    assign retire_count_o    = w_ret_cnt;
    assign credit_err_o      = r_err;
endmodule

// File: tb/tb_reorder_commit_unit.sv
// Directed plus randomized bench for reorder_commit_unit, checked every cycle
// against a queue-based reference model of the retire/commit rules.
module tb_reorder_commit_unit;
    localparam int NQ = 8, DEPTH = 64, IDD = 16, CD = 16, IDW = 6, RW = 2;
    localparam int SW = $clog2(NQ), RCW = $clog2(RW + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flush, tpush, tbrk, idpush, pull;
    logic [SW-1:0]  tsel;
    logic [IDW-1:0] idval;
    logic [NQ-1:0]  status;
    logic           full, cvalid, cfull, cerr;
    logic [IDW-1:0] cval;
    logic [RCW-1:0] rcnt;

    reorder_commit_unit #(
        .NUM_QUEUES(NQ), .DEPTH(DEPTH), .ID_DEPTH(IDD), .COMMIT_DEPTH(CD),
        .ID_WIDTH(IDW), .RETIRE_WIDTH(RW), .BREAKPOINT(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .full_o(full),
        .trace_push_i(tpush), .trace_sel_i(tsel), .trace_break_i(tbrk),
        .trace_id_push_i(idpush), .trace_id_value_i(idval),
        .queues_status_push_i(status), .commit_id_pull_i(pull),
        .commit_id_valid_o(cvalid), .commit_id_value_o(cval),
        .commit_id_full_o(cfull), .retire_count_o(rcnt), .credit_err_o(cerr)
    );

    typedef struct { int sel; bit brk; } tent_t;
    tent_t          m_tq[$];
    logic [IDW-1:0] m_iq[$];
    logic [IDW-1:0] m_cq[$];
    int             m_cred[NQ];
    int             m_used[NQ];
    int             m_nret;
    bit             m_commit;
    bit             m_err;
    int             n_cmp = 0, n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Retire decision from the rules: walk the oldest entries, spending a copy of the credits.
    function automatic void compute_retire();
        int avail[NQ];
        m_nret   = 0;
        m_commit = 0;
        for (int q = 0; q < NQ; q++) begin
            m_used[q] = 0;
            avail[q]  = m_cred[q];
        end
        if (rst || flush) return;
        for (int k = 0; k < RW; k++) begin
            if (k >= m_tq.size()) break;
            if (avail[m_tq[k].sel] == 0) break;
            if (m_tq[k].brk && (m_iq.size() == 0 || m_cq.size() == CD)) break;
            avail[m_tq[k].sel]--;
            m_used[m_tq[k].sel]++;
            m_nret++;
            if (m_tq[k].brk) begin
                m_commit = 1;
                break;
            end
        end
    endfunction

    function automatic void model_update();
        int tsz, isz;
        if (rst) begin
            m_tq.delete(); m_iq.delete(); m_cq.delete();
            for (int q = 0; q < NQ; q++) m_cred[q] = 0;
            m_err = 0;
            return;
        end
        compute_retire();
        tsz = m_tq.size();
        isz = m_iq.size();
        if (pull && m_cq.size() > 0) void'(m_cq.pop_front());
        if (flush) begin
            m_tq.delete(); m_iq.delete();
            for (int q = 0; q < NQ; q++) m_cred[q] = 0;
            return;
        end
        repeat (m_nret) void'(m_tq.pop_front());
        if (m_commit) m_cq.push_back(m_iq.pop_front());
        if (tpush && tsz < DEPTH) m_tq.push_back('{int'(tsel), bit'(tbrk)});
        if (idpush && isz < IDD) m_iq.push_back(idval);
        for (int q = 0; q < NQ; q++) begin
            if (status[q] && m_cred[q] == DEPTH && m_used[q] == 0) m_err = 1;
            else m_cred[q] = m_cred[q] + int'(status[q]) - m_used[q];
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        compute_retire();
        check("full_o", 32'(full), 32'(m_tq.size() == DEPTH || m_iq.size() == IDD));
        check("commit_valid", 32'(cvalid), 32'(m_cq.size() > 0));
        check("commit_value", 32'(cval), (m_cq.size() > 0) ? 32'(m_cq[0]) : 32'(0));
        check("commit_full", 32'(cfull), 32'(m_cq.size() == CD));
        check("retire_count", 32'(rcnt), 32'(m_nret));
        check("credit_err", 32'(cerr), 32'(m_err));
    endtask

    task automatic step_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        settle();
        step_edge();
    endtask

    task automatic idle();
        rst = 0; flush = 0; tpush = 0; tsel = '0; tbrk = 0;
        idpush = 0; idval = '0; status = '0; pull = 0;
    endtask

    task automatic randomize_inputs();
        flush  = 1'($urandom);
        tpush  = 1'($urandom);
        tsel   = SW'($urandom);
        tbrk   = 1'($urandom);
        idpush = 1'($urandom);
        idval  = IDW'($urandom);
        status = NQ'($urandom);
        pull   = 1'($urandom);
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    // Leaves the bench sampled (after settle) on the first cycle with a retire.
    task automatic wait_retire(input int bound);
        bit found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            settle();
            if (rcnt !== '0) found = 1;
            else step_edge();
        end
        n_cmp++;
        assert (found) else begin
            n_mis++;
            $error("FAIL wait_retire: observed no retire within %0d cycles, expected a retire", bound);
        end
    endtask

    initial begin
        idle();
        rst = 1; randomize_inputs();
        @(posedge clk); #1;
        randomize_inputs(); rst = 1;
        tick();
        idle();
        tpush = 1; tsel = SW'(2); tick(); idle();
        settle(); check("full_after_one", 32'(full), 32'(0)); step_edge();

        // single ID, breakpoint commit
        do_reset();
        tpush = 1; tsel = SW'(3); tbrk = 0; idpush = 1; idval = IDW'(6'h2A); tick();
        idle(); tpush = 1; tsel = SW'(5); tbrk = 1; tick();
        idle(); status[5] = 1; tick();
        idle(); status[3] = 1; tick();
        idle(); wait_retire(10);
        check("single_id_retire_cnt", 32'(rcnt), 32'(2));
        check("single_id_not_yet", 32'(cvalid), 32'(0)); step_edge();
        settle();
        check("single_id_valid", 32'(cvalid), 32'(1));
        check("single_id_value", 32'(cval), 32'(6'h2A));
        pull = 1; step_edge(); idle(); tick();

        // brk stalls on empty ID FIFO, then dual retire on the same queue
        do_reset();
        tpush = 1; tsel = SW'(0); tbrk = 1; status[0] = 1; tick();
        idle(); tpush = 1; tsel = SW'(1); status[1] = 1; tick();
        tpush = 1; tsel = SW'(1); status[1] = 1; tick();
        idle(); tpush = 1; tsel = SW'(2); tick();
        idle(); idpush = 1; idval = IDW'(6'h11); tick();
        idle(); wait_retire(5);
        check("brk_retires_alone", 32'(rcnt), 32'(1)); step_edge();
        settle(); check("dual_same_queue", 32'(rcnt), 32'(2)); step_edge();
        settle(); check("no_credit_blocks", 32'(rcnt), 32'(0)); step_edge();

        // trace FIFO full, dropped push, release after retire
        do_reset();
        tpush = 1; tsel = SW'(4); tbrk = 0;
        for (int i = 0; i < DEPTH; i++) tick();
        settle(); check("full_at_depth", 32'(full), 32'(1)); step_edge();
        idle(); status[4] = 1; tick();
        idle(); wait_retire(5);
        check("full_head_retire", 32'(rcnt), 32'(1));
        check("full_until_edge", 32'(full), 32'(1)); step_edge();
        settle(); check("full_drops", 32'(full), 32'(0)); step_edge();

        // credit overflow is sticky through flush, cleared by reset
        do_reset();
        status[0] = 1;
        for (int i = 0; i < DEPTH; i++) tick();
        settle(); check("no_err_at_depth", 32'(cerr), 32'(0)); step_edge();
        idle(); settle(); check("credit_err_set", 32'(cerr), 32'(1)); step_edge();
        flush = 1; tick(); flush = 0;
        settle(); check("err_held_flush", 32'(cerr), 32'(1)); step_edge();
        rst = 1; tick(); rst = 0;
        settle(); check("err_clr_rst", 32'(cerr), 32'(0)); step_edge();

        // flush keeps committed IDs and drops in-flight state
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tpush = 1; tsel = SW'(2); tbrk = 1; idpush = 1; idval = IDW'(7 + i); status[2] = 1; tick();
        end
        idle(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tpush = 1; tsel = SW'(6); tbrk = 1'($urandom); idpush = 1; idval = IDW'($urandom); tick();
        end
        idle(); flush = 1; tick(); flush = 0;
        settle();
        check("flush_trace_clear", 32'(full), 32'(0));
        check("flush_keeps_commit", 32'(cvalid), 32'(1)); step_edge();
        for (int i = 0; i < 3; i++) begin
            pull = 1; settle(); check("flush_commit_order", 32'(cval), 32'(7 + i)); step_edge();
        end
        idle(); settle(); check("commit_drained", 32'(cvalid), 32'(0)); step_edge();
        tpush = 1; tsel = SW'(2); tbrk = 0; tick(); idle();
        repeat (3) tick();

        // randomized traffic, alternating backpressure-heavy and free-flowing phases
        for (int i = 0; i < 2000; i++) begin
            bit heavy = ((i / 250) % 2) == 0;
            rst    = ($urandom_range(0, 399) == 0);
            flush  = ($urandom_range(0, 79) == 0);
            tpush  = ($urandom_range(0, 9) < 6);
            tsel   = SW'($urandom_range(0, NQ - 1));
            tbrk   = ($urandom_range(0, 2) == 0);
            idpush = ($urandom_range(0, 9) < 4);
            idval  = IDW'($urandom);
            status = heavy ? (NQ'($urandom) & NQ'($urandom) & NQ'($urandom)) : (NQ'($urandom) & NQ'($urandom));
            pull   = heavy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            tick();
        end
        idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/reorder_commit_unit.md
Name: reorder_commit_unit

Overview:
Next-generation in-order commit engine for the re-order logic. It tracks micro-op traces dispatched to NUM_QUEUES out-of-order execution queues and retires up to RETIRE_WIDTH micro-ops per cycle in program order, using per-queue completion credits. It pushes the instruction ID into a committed-ID FIFO when a breakpoint micro-op retires. Compared with the single-retire reorder_logic_top it adds multi-retire, flush, credit-overflow detection and a retire-count output.

Parameters:
NUM_QUEUES, 8, number of execution queues feeding completion status
DEPTH, 64, trace FIFO entries (power of two, >=4)
ID_DEPTH, 16, pending-ID FIFO entries (power of two)
COMMIT_DEPTH, 16, committed-ID FIFO entries (power of two)
ID_WIDTH, 6, instruction ID width
RETIRE_WIDTH, 2, maximum micro-ops retired per cycle (1..4)
BREAKPOINT, 1'b1, trace_break_i value that marks the last micro-op of an ID

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  synchronous clear of in-flight state
full_o  out  1  trace FIFO full OR pending-ID FIFO full
trace_push_i  in  1  push micro-op entry
trace_sel_i  in  $clog2(NUM_QUEUES)  queue executing the micro-op
trace_break_i  in  1  breakpoint flag of the entry
trace_id_push_i  in  1  push pending ID
trace_id_value_i  in  ID_WIDTH  ID value
queues_status_push_i  in  NUM_QUEUES  per-queue completion of that queue's oldest outstanding micro-op
commit_id_pull_i  in  1  pop committed ID
commit_id_valid_o  out  1  committed FIFO non-empty
commit_id_value_o  out  ID_WIDTH  head of committed FIFO (show-ahead)
commit_id_full_o  out  1  committed FIFO full
retire_count_o  out  $clog2(RETIRE_WIDTH+1)  micro-ops retired this cycle
credit_err_o  out  1  sticky credit overflow

Behaviour:
- Reset (rst_i=1 at an edge): all FIFOs empty, credits 0. Outputs: full_o=0, commit_id_valid_o=0, commit_id_value_o=0, commit_id_full_o=0, retire_count_o=0, credit_err_o=0. rst_i overrides flush_i and all pushes.
- Trace FIFO stores {sel, brk} with brk = (trace_break_i==BREAKPOINT). A push is accepted iff trace_push_i and the FIFO is not full. Fullness is count-based from registered state; there is no same-cycle retire bypass. A push on full is dropped.
- Pending-ID FIFO: push accepted iff trace_id_push_i and not full. It is independent of the trace FIFO.
- Credits: one counter per queue, width $clog2(DEPTH+1). Each edge: credit[q] <= credit[q] + status_push[q] - consumed[q]. A status push when credit[q]==DEPTH, with no consumption of q in the same cycle, saturates the counter and sets credit_err_o. credit_err_o clears only on rst_i.
- Retire (combinational from registered state, applied at the edge): scan slots k=0..RETIRE_WIDTH-1 from the trace head.
  - Slot k retires iff it is valid, all earlier slots retired, and credit[sel_k] > the number of earlier slots this cycle with the same sel.
  - A brk slot additionally requires the pending-ID FIFO non-empty and the committed FIFO not full.
  - The scan stops after the first brk slot, inclusive, so there is at most one commit per cycle.
- retire_count_o is the number of slots retiring this cycle (combinational).
- Commit: a retiring brk slot pops the pending-ID head and pushes it into the committed FIFO on the same edge.
- Latency: status pushes become visible one cycle later (registered credit). A micro-op pushed at edge t, with credit available, retires at edge t+1. If it is a brk, commit_id_valid_o rises after edge t+1.
- Committed FIFO: a pull with valid pops the head. A pull on empty is ignored. Push and pull in the same cycle when full: the pull is applied and the push is blocked, because the retire condition uses registered full.
- Flush (flush_i=1, rst_i=0): trace FIFO, pending-ID FIFO and credits are cleared. The committed FIFO and credit_err_o are kept. Trace, ID and status pushes in that cycle are dropped, and retire_count_o=0.
- Pointers wrap modulo depth, with an extra MSB for the full/empty distinction.
- A brk retire with an empty pending-ID FIFO stalls; this is not an error.

Test Plan:
- Reset: hold rst_i 2 cycles with all inputs toggling -> all outputs 0, then push 1 entry -> full_o stays 0.
- Single ID: push sel=3 (brk=0), sel=5 (brk=1), ID=0x2A; pulse status[5] then status[3] -> sel=3 retires first, then sel=5. commit_id_value_o=0x2A valid exactly 1 cycle after the brk retire.
- Dual retire: RETIRE_WIDTH=2, entries sel=1, sel=1, sel=2, credit[1]=1 -> retire_count_o=1. After credit[1]=2 -> retire_count_o=2 in one cycle.
- Full: push DEPTH entries with no credits -> full_o=1, the 65th push is dropped. One status push for the head queue -> full_o drops one cycle after the retire.
- Credit overflow: DEPTH+1 status pushes on queue 0 with no entries -> credit_err_o=1, held through flush_i, cleared by rst_i.
- Flush: 3 committed IDs pending plus 10 in-flight entries, pulse flush_i -> committed FIFO still yields 3 IDs in order, trace and ID FIFOs empty, credits 0.
